// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - multi-digit BCD countdown timer
// Loads a BCD preset, decrements once per qualified tick, pulses done at zero.
module bcd_countdown_timer #(
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  tick_en,
   output logic [4*DIGITS-1:0]   q,
   output logic                  busy,
   output logic                  done,
   output logic                  load_err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_PAUSED = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [4*DIGITS-1:0]   r_q;
   logic [4*DIGITS-1:0]   w_q_nxt;
   logic [4*DIGITS-1:0]   w_q_dec;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_err;
   logic                  w_done_nxt;
   logic                  w_err_nxt;
   logic                  w_load_ok;
   logic                  w_q_zero;
   logic                  w_dec_zero;
   logic                  w_borrow;

   // Ripple borrow from the LS digit; a 0 digit becomes 9 and passes the borrow on.
   always_comb begin
      w_q_dec  = r_q;
      w_borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_borrow) begin
            if (r_q[4*i +: 4] == 4'd0) begin
               w_q_dec[4*i +: 4] = 4'd9;
            end else begin
               w_q_dec[4*i +: 4] = r_q[4*i +: 4] - 4'd1;
               w_borrow          = 1'b0;
            end
         end
      end
   end

   always_comb begin
      w_load_ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (load_val[4*i +: 4] > 4'd9) begin
            w_load_ok = 1'b0;
         end
      end
   end

   assign w_q_zero   = (r_q == '0);
   assign w_dec_zero = (w_q_dec == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_q     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_q     <= w_q_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // Priority: load > start > pause > tick_en; the highest asserted input owns the cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      if (load) begin
         if (w_load_ok) begin
            w_q_nxt     = load_val;
            w_state_nxt = S_IDLE;
         end else begin
            w_err_nxt   = 1'b1;
         end
      end else if (start) begin
         if (r_state != S_RUN) begin
            if (w_q_zero) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
      end else if (pause) begin
         if (r_state == S_RUN) begin
            w_state_nxt = S_PAUSED;
         end
      end else if ((r_state == S_RUN) && tick_en && !w_q_zero) begin
         w_q_nxt = w_q_dec;
         if (w_dec_zero) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
         end
      end
   end

   assign q        = r_q;
   assign busy     = r_busy;
   assign done     = r_done;
   assign load_err = r_err;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - directed bench for bcd_countdown_timer
// Two instances: the default 2-digit timer and a 3-digit one for the borrow chain.
module tb_bcd_countdown_timer;

   logic        clk;
   logic        rst_n;
   logic        load, start, pause, tick_en;
   logic [7:0]  load_val;
   logic [7:0]  q;
   logic        busy, done, load_err;

   logic        load3, start3, pause3, tick3;
   logic [11:0] load_val3;
   logic [11:0] q3;
   logic        busy3, done3, load_err3;

   int          n_pass;
   int          n_fail;
   int          n_total;
   logic [7:0]  e;

   bcd_countdown_timer #(.DIGITS(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
      .start(start), .pause(pause), .tick_en(tick_en),
      .q(q), .busy(busy), .done(done), .load_err(load_err)
   );

   bcd_countdown_timer #(.DIGITS(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .load(load3), .load_val(load_val3),
      .start(start3), .pause(pause3), .tick_en(tick3),
      .q(q3), .busy(busy3), .done(done3), .load_err(load_err3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_pass = 0; n_fail = 0; n_total = 0;
      rst_n = 1'b0;
      load = 0; start = 0; pause = 0; tick_en = 0; load_val = 8'h00;
      load3 = 0; start3 = 0; pause3 = 0; tick3 = 0; load_val3 = 12'h000;
      cyc(); cyc();
      chk("rst_q", q, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", load_err, 1'b0);
      rst_n = 1'b1;
      cyc();

      // Count 12 down to 00; tick in the start cycle must be ignored
      load = 1; load_val = 8'h12; cyc(); load = 0;
      chk("t2_load_q", q, 8'h12);
      chk("t2_load_busy", busy, 1'b0);
      start = 1; tick_en = 1; cyc(); start = 0;
      chk("t2_start_q", q, 8'h12);
      chk("t2_start_busy", busy, 1'b1);
      for (int n = 11; n >= 0; n--) begin
         cyc();
         e[7:4] = 4'(n / 10);
         e[3:0] = 4'(n % 10);
         chk("t2_q", q, e);
         chk("t2_done", done, (n == 0));
         chk("t2_busy", busy, (n != 0));
      end
      cyc();
      chk("t2_done_low", done, 1'b0);
      chk("t2_hold_q", q, 8'h00);
      tick_en = 0;

      // Borrow across two digits on the 3-digit instance
      load3 = 1; load_val3 = 12'h100; cyc(); load3 = 0;
      start3 = 1; cyc(); start3 = 0;
      tick3 = 1; cyc();
      chk("t3_q099", q3, 12'h099);
      cyc(); tick3 = 0;
      chk("t3_q098", q3, 12'h098);
      chk("t3_busy", busy3, 1'b1);

      // Invalid load rejected; start at zero pulses done without running
      load = 1; load_val = 8'h1A; cyc(); load = 0;
      chk("t4_err", load_err, 1'b1);
      chk("t4_err_q", q, 8'h00);
      cyc();
      chk("t4_err_low", load_err, 1'b0);
      load = 1; load_val = 8'h00; cyc(); load = 0;
      start = 1; cyc(); start = 0;
      chk("t4_done", done, 1'b1);
      chk("t4_busy", busy, 1'b0);
      cyc();
      chk("t4_done_low", done, 1'b0);
      chk("t4_busy2", busy, 1'b0);

      // Pause holds the count while tick_en stays high; start resumes
      load = 1; load_val = 8'h05; cyc(); load = 0;
      start = 1; cyc(); start = 0;
      tick_en = 1; cyc(); cyc();
      chk("t5_q03", q, 8'h03);
      pause = 1; cyc(); pause = 0;
      chk("t5_pause_q", q, 8'h03);
      chk("t5_pause_busy", busy, 1'b1);
      cyc(); cyc();
      chk("t5_hold_q", q, 8'h03);
      start = 1; cyc(); start = 0;
      chk("t5_resume_q", q, 8'h03);
      cyc(); chk("t5_q02", q, 8'h02);
      cyc(); chk("t5_q01", q, 8'h01);
      chk("t5_nodone", done, 1'b0);
      cyc(); chk("t5_q00", q, 8'h00);
      chk("t5_done", done, 1'b1);
      chk("t5_idle", busy, 1'b0);
      tick_en = 0;

      // Load beats start and pause; start beats pause from IDLE
      load = 1; load_val = 8'h20; cyc(); load = 0;
      start = 1; cyc(); start = 0;
      tick_en = 1; cyc(); tick_en = 0;
      chk("t6_q19", q, 8'h19);
      load = 1; load_val = 8'h40; start = 1; pause = 1; cyc();
      load = 0; start = 0; pause = 0;
      chk("t6_load_q", q, 8'h40);
      chk("t6_load_busy", busy, 1'b0);
      start = 1; pause = 1; cyc(); start = 0; pause = 0;
      chk("t6_sp_busy", busy, 1'b1);
      tick_en = 1; cyc(); tick_en = 0;
      chk("t6_q39", q, 8'h39);

      // Asynchronous reset mid-run at 37
      load = 1; load_val = 8'h37; cyc(); load = 0;
      start = 1; cyc(); start = 0;
      chk("t1_run_busy", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("t1_q", q, 8'h00);
      chk("t1_busy", busy, 1'b0);
      chk("t1_done", done, 1'b0);
      cyc();
      chk("t1_done_hold", done, 1'b0);
      rst_n = 1'b1;
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
